// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: round-robin sharing of one ALU among NREQ requesters with a valid/ready response channel
module alu_share_ctrl #(
  parameter int NREQ    = 2,
  parameter int WIDTH   = 4,
  parameter int ALU_LAT = 1,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [3*NREQ-1:0]       req_opcode,
  input  logic [WIDTH*NREQ-1:0]   req_a,
  input  logic [WIDTH*NREQ-1:0]   req_b,
  output logic [2:0]              alu_opcode,
  output logic [WIDTH-1:0]        alu_a,
  output logic [WIDTH-1:0]        alu_b,
  input  logic [WIDTH-1:0]        alu_result,
  input  logic [3:0]              alu_status,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [WIDTH-1:0]        rsp_result,
  output logic [3:0]              rsp_status,
  output logic                    busy
);
  localparam int CW = $clog2(ALU_LAT + 1);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic [ID_W-1:0] rr_ptr, grant;
  logic [CW-1:0] cnt;
  logic [2*NREQ-1:0] rot;
  logic [ID_W:0] sum;
  logic any_valid, accept;
  // Rotate so bit 0 is rr_ptr; the highest-index hit is overwritten by lower ones, leaving the nearest.
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr;
    grant = '0;
    any_valid = 1'b0;
    sum = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = {1'b0, rr_ptr} + (ID_W + 1)'(i);
        grant = (sum >= (ID_W + 1)'(NREQ)) ? ID_W'(sum - (ID_W + 1)'(NREQ)) : ID_W'(sum);
        any_valid = 1'b1;
      end
    end
  end
  always_comb begin
    accept = (state == IDLE) && any_valid;
    req_ready = (accept && reset) ? (NREQ'(1) << grant) : '0;
    state_nx = (state == IDLE) ? (any_valid ? EXEC : IDLE) :
               (state == EXEC) ? ((cnt == CW'(1)) ? RESP : EXEC) :
               (rsp_ready ? IDLE : RESP);
    busy = (state != IDLE);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      alu_opcode <= '0;
      alu_a <= '0;
      alu_b <= '0;
      rsp_valid <= 1'b0;
      rsp_id <= '0;
      rsp_result <= '0;
      rsp_status <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_opcode <= req_opcode[3*grant +: 3];
        alu_a <= req_a[WIDTH*grant +: WIDTH];
        alu_b <= req_b[WIDTH*grant +: WIDTH];
        rsp_id <= grant;
        cnt <= CW'(ALU_LAT);
      end
      if (state == EXEC) begin
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          rsp_result <= alu_result;
          rsp_status <= alu_status;
          rsp_valid <= 1'b1;
        end
      end
      if (state == RESP && rsp_ready) begin
        rsp_valid <= 1'b0;
        rr_ptr <= (rsp_id == ID_W'(NREQ - 1)) ? '0 : rsp_id + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb_alu_share_ctrl: directed checks of arbitration, latency, backpressure, reset and pointer wrap
module tb_alu_share_ctrl;
  logic clk = 0, reset;
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0, g;

  // opcodes: 000 AND, 001 OR, 010 ADD, 011 SUB, others XOR; status = {zero, opcode}
  function automatic logic [7:0] alu_f(logic [2:0] op, logic [3:0] a, logic [3:0] b);
    logic [3:0] r;
    r = (op == 3'd0) ? (a & b) : (op == 3'd1) ? (a | b) : (op == 3'd2) ? (a + b) :
        (op == 3'd3) ? (a - b) : (a ^ b);
    return {r == 4'd0, op, r};
  endfunction

  logic [1:0] v1, rdy1; logic [5:0] op1; logic [7:0] a1, b1;
  logic [2:0] ao1; logic [3:0] aa1, ab1, ar1, as1, res1, st1; logic rv1, rk1, id1, bz1;
  assign {as1, ar1} = alu_f(ao1, aa1, ab1);
  alu_share_ctrl #(.NREQ(2), .WIDTH(4), .ALU_LAT(1), .ID_W(1)) d1 (
    .clk(clk), .reset(reset), .req_valid(v1), .req_ready(rdy1), .req_opcode(op1), .req_a(a1), .req_b(b1),
    .alu_opcode(ao1), .alu_a(aa1), .alu_b(ab1), .alu_result(ar1), .alu_status(as1),
    .rsp_valid(rv1), .rsp_ready(rk1), .rsp_id(id1), .rsp_result(res1), .rsp_status(st1), .busy(bz1));

  logic [1:0] v3, rdy3; logic [5:0] op3; logic [7:0] a3, b3;
  logic [2:0] ao3; logic [3:0] aa3, ab3, ar3, as3, res3, st3; logic rv3, rk3, id3, bz3;
  assign {as3, ar3} = alu_f(ao3, aa3, ab3);
  alu_share_ctrl #(.NREQ(2), .WIDTH(4), .ALU_LAT(3), .ID_W(1)) d3 (
    .clk(clk), .reset(reset), .req_valid(v3), .req_ready(rdy3), .req_opcode(op3), .req_a(a3), .req_b(b3),
    .alu_opcode(ao3), .alu_a(aa3), .alu_b(ab3), .alu_result(ar3), .alu_status(as3),
    .rsp_valid(rv3), .rsp_ready(rk3), .rsp_id(id3), .rsp_result(res3), .rsp_status(st3), .busy(bz3));

  logic [2:0] vw, rdyw; logic [8:0] opw; logic [11:0] aw, bw;
  logic [2:0] aow; logic [3:0] aaw, abw, arw, asw, resw, stw; logic rvw, rkw, bzw; logic [1:0] idw;
  assign {asw, arw} = alu_f(aow, aaw, abw);
  alu_share_ctrl #(.NREQ(3), .WIDTH(4), .ALU_LAT(1), .ID_W(2)) dw (
    .clk(clk), .reset(reset), .req_valid(vw), .req_ready(rdyw), .req_opcode(opw), .req_a(aw), .req_b(bw),
    .alu_opcode(aow), .alu_a(aaw), .alu_b(abw), .alu_result(arw), .alu_status(asw),
    .rsp_valid(rvw), .rsp_ready(rkw), .rsp_id(idw), .rsp_result(resw), .rsp_status(stw), .busy(bzw));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    reset = 0;
    {v1, op1, a1, b1, v3, op3, a3, b3, vw, opw, aw, bw} = '0;
    rk1 = 1; rk3 = 1; rkw = 1;
    tick(); tick();
    check("rst_outputs", {rv1, bz1, ao1, aa1, ab1, res1, st1, id1}, 0);
    reset = 1;
    // single request ADD 3+4
    tick();
    v1 = 2'b01; op1[2:0] = 3'b010; a1[3:0] = 4'd3; b1[3:0] = 4'd4; #1;
    check("t2_ready", rdy1, 2'b01);
    check("t2_idle", bz1, 0);
    tick(); v1 = 0;
    check("t2_busy_exec", bz1, 1);
    check("t2_alu", {ao1, aa1, ab1}, {3'b010, 4'd3, 4'd4});
    check("t2_rv_exec", rv1, 0);
    tick();
    check("t2_rsp", {rv1, id1, res1, st1, bz1}, {1'b1, 1'b0, 4'd7, 4'b0010, 1'b1});
    tick();
    check("t2_done", {bz1, rv1}, 0);
    // reset asserted while an operation is executing
    v1 = 2'b01; #1;
    tick();
    check("t1_in_exec", bz1, 1);
    reset = 0; #1;
    check("t1_rst_out", {rv1, bz1, ao1, aa1, ab1, res1, st1, id1}, 0);
    check("t1_rst_ready", rdy1, 0);
    v1 = 0;
    tick(); reset = 1;
    tick();
    check("t1_no_stale", {rv1, bz1}, 0);
    tick();
    check("t1_no_stale2", {rv1, bz1}, 0);
    // contention: req0 AND, req1 OR
    v1 = 2'b11; op1 = {3'b001, 3'b000}; a1 = {4'hC, 4'hC}; b1 = {4'hA, 4'hA}; #1;
    for (int i = 0; i < 4; i++) begin
      g = i % 2;
      check("t3_grant", rdy1, g ? 2'b10 : 2'b01);
      tick();
      check("t3_alu_op", ao1, g);
      tick();
      check("t3_rsp", {rv1, id1, res1}, {1'b1, g[0], g ? 4'hE : 4'h8});
      if (i == 3) v1 = 0;
      tick();
    end
    // backpressure with req1 waiting
    rk1 = 0; v1 = 2'b01; op1[2:0] = 3'b010; a1[3:0] = 4'd5; b1[3:0] = 4'd6; #1;
    check("t4_ready", rdy1, 2'b01);
    tick(); v1 = 2'b10;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("t4_hold", {rv1, id1, st1, res1}, {1'b1, 1'b0, 4'b0010, 4'hB});
      check("t4_no_ready", rdy1, 0);
      tick();
    end
    rk1 = 1;
    tick();
    check("t4_release", {rv1, bz1}, 0);
    check("t4_next_grant", rdy1, 2'b10);
    v1 = 0;
    // ALU_LAT=3: SUB 9-2
    tick();
    v3 = 2'b01; op3[2:0] = 3'b011; a3[3:0] = 4'd9; b3[3:0] = 4'd2; #1;
    check("t5_ready", rdy3, 2'b01);
    tick(); v3 = 0; a3[3:0] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      check("t5_alu_hold", {ao3, aa3, ab3}, {3'b011, 4'd9, 4'd2});
      check("t5_rv_low", rv3, 0);
      tick();
    end
    check("t5_rsp", {rv3, id3, res3, ao3, aa3}, {1'b1, 1'b0, 4'd7, 3'b011, 4'd9});
    tick();
    check("t5_done", {rv3, bz3}, 0);
    // NREQ=3 wrap: prime pointer with req1, then req2/req0 alternate
    vw = 3'b010; opw = {3'b010, 3'b010, 3'b010}; aw = {4'd4, 4'd7, 4'd1}; bw = {4'd5, 4'd7, 4'd1}; #1;
    check("t6_prime_ready", rdyw, 3'b010);
    tick(); vw = 0;
    tick();
    check("t6_prime_rsp", {rvw, idw, resw}, {1'b1, 2'd1, 4'hE});
    tick();
    vw = 3'b101; #1;
    for (int i = 0; i < 4; i++) begin
      g = (i % 2) ? 0 : 2;
      check("t6_grant", rdyw, g ? 3'b100 : 3'b001);
      tick(); tick();
      check("t6_rsp", {rvw, idw, resw}, {1'b1, g[1:0], g ? 4'd9 : 4'd2});
      if (i == 3) vw = 0;
      tick();
    end
    check("t6_idle", {bzw, rvw}, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
